// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable clock divider with glitch-free divisor updates.
//
// A half-period counter toggles clkdvd every H system clocks and emits single-cycle
// rise/fall ticks so downstream logic can stay in the clk domain. A new half-period
// length is loaded through a one-deep pending slot and becomes active only at a
// half-period boundary, so a half in progress always completes with its old length.
//
// Optional feature macro: CLKDIV_DUTY_EN
//   defined   -> port div_lo_in exists; div_in sets the high half, div_lo_in the low half.
//   undefined -> both halves use div_in (50% duty).
//
// Handshake (valid/ready): a transfer happens on a posedge where div_valid && div_ready.
// div_ready is 1 exactly when the pending slot is empty. The master must hold div_valid
// and its data stable until the transfer; div_valid while div_ready=0 is ignored.
// Once accepted, div_ready stays 0 until the pending value has been applied.
module clkdiv_prog #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0] div_lo_in,
`endif
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clkdvd,
    output logic             rise_tick,
    output logic             fall_tick
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Zero is not a meaningful half-length; treat it as the fastest setting.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    // Requested low-half length: its own port with the duty feature, else same as high.
    logic [CNT_W-1:0] lo_req;
`ifdef CLKDIV_DUTY_EN
    assign lo_req = div_lo_in;
`else
    assign lo_req = div_in;
`endif

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_hi;
    logic [CNT_W-1:0] act_lo;
    logic [CNT_W-1:0] pend_hi;
    logic [CNT_W-1:0] pend_lo;
    logic             pend_v;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;

    // Length of the half currently in progress and the last-cycle-of-half flag.
    logic [CNT_W-1:0] h_cur;
    logic             at_bound;

    assign h_cur    = clk_q ? act_hi : act_lo;
    assign at_bound = (cnt == (h_cur - ONE));

    assign div_ready = ~pend_v;
    assign clkdvd    = clk_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

    // Counter, divided clock, ticks, pending slot and active divisors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            act_hi  <= DIV_RST;
            act_lo  <= DIV_RST;
            pend_hi <= DIV_RST;
            pend_lo <= DIV_RST;
            pend_v  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            // Accept a new divisor only into an empty slot; the apply paths below
            // need pend_v=1, so capture and apply never coincide.
            if (div_valid && !pend_v) begin
                pend_hi <= clamp_div(div_in);
                pend_lo <= clamp_div(lo_req);
                pend_v  <= 1'b1;
            end

            if (en) begin
                if (at_bound) begin
                    clk_q  <= ~clk_q;
                    cnt    <= '0;
                    rise_q <= ~clk_q;
                    fall_q <= clk_q;
                    // pend_v was set on an earlier edge, so the capture was strictly
                    // before this boundary; the next half starts with the new length.
                    if (pend_v) begin
                        act_hi <= pend_hi;
                        act_lo <= pend_lo;
                        pend_v <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end else if (pend_v) begin
                // Frozen: nothing to protect, so apply at once and restart the half.
                act_hi <= pend_hi;
                act_lo <= pend_lo;
                pend_v <= 1'b0;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed self-checking bench for clkdiv_prog.
// Edge numbering: edge 1 is the first posedge after rst is released. Outputs are
// sampled 1 ns after each posedge; inputs are also changed at that point.
module tb_clkdiv_prog;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] div_lo_in;
    logic             div_valid;
    logic             div_ready;
    logic             clkdvd;
    logic             rise_tick;
    logic             fall_tick;

    int checks = 0;
    int errors = 0;

    clkdiv_prog #(.CNT_W(CNT_W), .DIV_RESET(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
`ifdef CLKDIV_DUTY_EN
        .div_lo_in (div_lo_in),
`endif
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clkdvd    (clkdvd),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, release 1 ns after a posedge; next posedge is edge 1.
    task automatic do_reset(input logic en_val);
        rst       = 1'b0;
        en        = en_val;
        div_valid = 1'b0;
        div_in    = '0;
        div_lo_in = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        div_valid = 1'b0;
        step();
        checks++;
        if (clkdvd !== 1'b0 || rise_tick !== 1'b0 || fall_tick !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: clkdvd=%b rise=%b fall=%b ready=%b required 0 0 0 1",
                     clkdvd, rise_tick, fall_tick, div_ready);
        end
    endtask

    // H=4: rise on edge 4, fall on edge 8.
    task automatic test_basic();
        logic e_clk, e_r, e_f;
        do_reset(1'b1);
        for (int e = 1; e <= 9; e++) begin
            step();
            e_clk = (e >= 4 && e < 8) || (e == 9 && 1'b0);
            e_r   = (e == 4);
            e_f   = (e == 8);
            checks++;
            if (clkdvd !== e_clk || rise_tick !== e_r || fall_tick !== e_f) begin
                errors++;
                $display("FAIL basic_e%0d: clk/rise/fall=%b%b%b required %b%b%b",
                         e, clkdvd, rise_tick, fall_tick, e_clk, e_r, e_f);
            end
        end
    endtask

    // Load 2 mid-high-half (capture edge 6); the high half still ends at edge 8.
    task automatic test_load_mid();
        logic [8:0] exp_clk = 9'b110011001;  // edges 6..14, MSB = edge 6
        logic [8:0] exp_rdy = 9'b001111111;
        logic e_r, e_f;
        do_reset(1'b1);
        for (int e = 1; e <= 5; e++) step();
        div_in    = 16'd2;
        div_valid = 1'b1;
        for (int e = 6; e <= 14; e++) begin
            step();
            div_valid = 1'b0;
            e_r = (e == 10 || e == 14);
            e_f = (e == 8 || e == 12);
            checks++;
            if (clkdvd !== exp_clk[14-e] || div_ready !== exp_rdy[14-e] ||
                rise_tick !== e_r || fall_tick !== e_f) begin
                errors++;
                $display("FAIL load_mid_e%0d: clk/rdy/rise/fall=%b%b%b%b required %b%b%b%b",
                         e, clkdvd, div_ready, rise_tick, fall_tick,
                         exp_clk[14-e], exp_rdy[14-e], e_r, e_f);
            end
        end
    endtask

    // Load 0 -> clamped to 1; applied at edge 4, then toggling every clock.
    task automatic test_div_zero();
        logic e_clk;
        do_reset(1'b1);
        div_in    = 16'd0;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_capture_ready: ready=%b required 0", div_ready);
        end
        for (int e = 2; e <= 12; e++) begin
            step();
            if (e >= 4) begin
                e_clk = (e % 2 == 0);
                checks++;
                if (clkdvd !== e_clk || rise_tick !== e_clk || fall_tick !== !e_clk) begin
                    errors++;
                    $display("FAIL zero_e%0d: clk/rise/fall=%b%b%b required %b%b%b",
                             e, clkdvd, rise_tick, fall_tick, e_clk, e_clk, !e_clk);
                end
            end
        end
    endtask

    // Freeze at CNT=2 in the high half; after resume the fall comes 2 edges later.
    task automatic test_enable_freeze();
        do_reset(1'b1);
        for (int e = 1; e <= 6; e++) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (clkdvd !== 1'b1 || rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze_c%0d: clk/rise/fall=%b%b%b required 100",
                         i, clkdvd, rise_tick, fall_tick);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (clkdvd !== 1'b1 || rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_first: clk/rise/fall=%b%b%b required 100",
                     clkdvd, rise_tick, fall_tick);
        end
        step();
        checks++;
        if (clkdvd !== 1'b0 || fall_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_toggle: clk/fall=%b%b required 01", clkdvd, fall_tick);
        end
    endtask

    // en=0: capture edge 1, apply edge 2 with CNT<=0; H=2 then gives rise on edge 4.
    task automatic test_apply_disabled();
        do_reset(1'b0);
        div_in    = 16'd2;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("FAIL dis_capture_ready: ready=%b required 0", div_ready);
        end
        step();
        checks++;
        if (div_ready !== 1'b1 || clkdvd !== 1'b0) begin
            errors++;
            $display("FAIL dis_apply: ready/clk=%b%b required 10", div_ready, clkdvd);
        end
        en = 1'b1;
        step();
        checks++;
        if (clkdvd !== 1'b0) begin
            errors++;
            $display("FAIL dis_e3: clk=%b required 0", clkdvd);
        end
        step();
        checks++;
        if (clkdvd !== 1'b1 || rise_tick !== 1'b1) begin
            errors++;
            $display("FAIL dis_e4: clk/rise=%b%b required 11", clkdvd, rise_tick);
        end
    endtask

    // Capture on boundary edge 4 (waits until edge 8); second load held off until then.
    task automatic test_back_to_back();
        logic e_clk, e_rdy;
        do_reset(1'b1);
        for (int e = 1; e <= 3; e++) step();
        div_in    = 16'd2;
        div_valid = 1'b1;
        step();  // edge 4: boundary and capture
        div_in = 16'd3;  // second request, held
        for (int e = 5; e <= 14; e++) begin
            step();
            if (e == 9) div_valid = 1'b0;
            // H=4 until edge 8, H=2 to edge 10, then H=3: fall at 13
            e_clk = (e < 8) || (e >= 10 && e < 13);
            e_rdy = (e == 8) || (e >= 10);
            checks++;
            if (clkdvd !== e_clk || div_ready !== e_rdy) begin
                errors++;
                $display("FAIL b2b_e%0d: clk/rdy=%b%b required %b%b",
                         e, clkdvd, div_ready, e_clk, e_rdy);
            end
        end
    endtask

    // Async reset mid-high with a pending value: immediate clear, pending discarded.
    task automatic test_async_reset();
        logic e_clk;
        do_reset(1'b1);
        for (int e = 1; e <= 5; e++) step();
        div_in    = 16'd1;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if (clkdvd !== 1'b0 || rise_tick !== 1'b0 || fall_tick !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: clk/rise/fall/rdy=%b%b%b%b required 0001",
                     clkdvd, rise_tick, fall_tick, div_ready);
        end
        step();
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            e_clk = (e >= 4 && e < 8);
            checks++;
            if (clkdvd !== e_clk) begin
                errors++;
                $display("FAIL post_reset_e%0d: clk=%b required %b", e, clkdvd, e_clk);
            end
        end
    endtask

`ifdef CLKDIV_DUTY_EN
    // HH=3, HL=5 applied at edge 4: high 4..6, low 7..11, high 12..14, low 15..19, rise 20.
    task automatic test_duty();
        logic e_clk, e_r, e_f;
        do_reset(1'b1);
        div_in    = 16'd3;
        div_lo_in = 16'd5;
        div_valid = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            step();
            div_valid = 1'b0;
            e_clk = (e >= 4 && e < 7) || (e >= 12 && e < 15) || (e >= 20);
            e_r   = (e == 4 || e == 12 || e == 20);
            e_f   = (e == 7 || e == 15);
            checks++;
            if (clkdvd !== e_clk || rise_tick !== e_r || fall_tick !== e_f) begin
                errors++;
                $display("FAIL duty_e%0d: clk/rise/fall=%b%b%b required %b%b%b",
                         e, clkdvd, rise_tick, fall_tick, e_clk, e_r, e_f);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (clkdvd !== 1'b0 || rise_tick !== 1'b0) begin
            errors++;
            $display("FAIL duty_async_reset: clk/rise=%b%b required 00", clkdvd, rise_tick);
        end
        step();
        rst = 1'b1;
    endtask
`endif

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        div_in    = '0;
        div_lo_in = '0;
        div_valid = 1'b0;
        test_reset();
        test_basic();
        test_load_mid();
        test_div_zero();
        test_enable_freeze();
        test_apply_disabled();
        test_back_to_back();
        test_async_reset();
`ifdef CLKDIV_DUTY_EN
        test_duty();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
